// File: rtl/jk_excite_driver_if.sv
// Bus bundle between a controller and jk_excite_driver: run request, target
// pattern, flip-flop feedback, J/K drive and run status.
interface jk_excite_driver_if #(
  parameter int LEN = 8
);
  localparam int ERR_W = $clog2(LEN + 1);
  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;

  logic             start;
  logic [LEN-1:0]   pattern;
  logic             q_fb;
  logic             j;
  logic             k;
  logic             busy;
  logic             done;
  logic [ERR_W-1:0] err_cnt;
  logic [IDX_W-1:0] cur_idx;

  modport master (
    output start, pattern, q_fb,
    input  j, k, busy, done, err_cnt, cur_idx
  );

  modport slave (
    input  start, pattern, q_fb,
    output j, k, busy, done, err_cnt, cur_idx
  );
endinterface

// File: rtl/jk_excite_driver.sv
// Steps an external JK flip-flop through a captured Q pattern, one DRIVE and
// one CHECK cycle per bit, counting bits where the fed-back Q disagrees.
module jk_excite_driver #(
  parameter int   LEN    = 8,
  parameter logic DC_VAL = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  jk_excite_driver_if.slave bus
);
  localparam int ERR_W = $clog2(LEN + 1);
  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(LEN);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_CHECK  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN-1:0]   pattern_q, pattern_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic             j_s, k_s, done_s;
  logic             target_s;

  assign target_s = pattern_q[cur_idx_q];

  // State and run bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pattern_q <= {LEN{1'b0}};
      err_cnt_q <= {ERR_W{1'b0}};
      cur_idx_q <= {IDX_W{1'b0}};
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      err_cnt_q <= err_cnt_d;
      cur_idx_q <= cur_idx_d;
    end
  end

  // Next-state logic and J/K excitation decode
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    err_cnt_d = err_cnt_q;
    cur_idx_d = cur_idx_q;
    j_s       = 1'b0;
    k_s       = 1'b0;
    done_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_DRIVE;
          pattern_d = bus.pattern;
          err_cnt_d = {ERR_W{1'b0}};
          cur_idx_d = {IDX_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        state_d = S_CHECK;
        if (!bus.q_fb) begin
          j_s = target_s;
          k_s = DC_VAL;
        end else begin
          j_s = DC_VAL;
          k_s = ~target_s;
        end
      end
      S_CHECK: begin
        if ((bus.q_fb != target_s) && (err_cnt_q != ERR_MAX)) begin
          err_cnt_d = err_cnt_q + ERR_ONE;
        end else begin
          err_cnt_d = err_cnt_q;
        end
        // With LEN = 1 the index never moves; LAST_IDX is 0.
        if (cur_idx_q == LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          state_d   = S_DRIVE;
          cur_idx_d = cur_idx_q + IDX_ONE;
        end
      end
      S_FINISH: begin
        done_s  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.j       = j_s;
  assign bus.k       = k_s;
  assign bus.done    = done_s;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.err_cnt = err_cnt_q;
  assign bus.cur_idx = cur_idx_q;
endmodule

// File: tb/tb_jk_excite_driver.sv
// Directed and randomized runs of jk_excite_driver against a JK flip-flop
// model, checked per cycle against a bit-level reference of the run.
module tb_jk_excite_driver;
  localparam int LEN = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jk_excite_driver_if #(.LEN(LEN)) bus();

  jk_excite_driver #(.LEN(LEN), .DC_VAL(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   mode = 0;   // 0: ideal FF, 1: Q stuck at 0, 2: Q stuck at 1
  logic ff_q;
  logic model_q;
  int   checks   = 0;
  int   failures = 0;

  // Ideal external JK flip-flop, cleared with the block reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= 1'b0;
    else begin
      case ({bus.j, bus.k})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  assign bus.q_fb = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ff_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One run from the IDLE cycle in which start is raised to the IDLE cycle after FINISH.
  task automatic run(input logic [7:0] pat, input bit hold, input bit scramble);
    int   errs = 0;
    logic qb, t, ej, ek;
    bus.pattern = pat;
    bus.start   = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      t  = pat[i];
      qb = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : model_q;
      ej = qb ? 1'b0 : t;
      ek = qb ? ~t : 1'b0;
      chk("drive_busy", 32'(bus.busy), 32'd1);
      chk("drive_done", 32'(bus.done), 32'd0);
      chk("drive_idx",  32'(bus.cur_idx), 32'(i));
      chk("drive_jk",   32'({bus.j, bus.k}), 32'({ej, ek}));
      chk("drive_err",  32'(bus.err_cnt), 32'(errs));
      if (scramble) bus.pattern = 8'($urandom);
      @(negedge clk);
      if (mode == 0) model_q = t;
      if (((mode == 0) ? t : qb) != t) errs++;
      chk("check_jk",   32'({bus.j, bus.k}), 32'd0);
      chk("check_idx",  32'(bus.cur_idx), 32'(i));
      chk("check_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    chk("finish_done", 32'(bus.done), 32'd1);
    chk("finish_busy", 32'(bus.busy), 32'd1);
    chk("finish_jk",   32'({bus.j, bus.k}), 32'd0);
    chk("finish_err",  32'(bus.err_cnt), 32'(errs));
    @(negedge clk);
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_err",  32'(bus.err_cnt), 32'(errs));
    chk("idle_idx",  32'(bus.cur_idx), 32'(LEN - 1));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n   = 1'b1;
    model_q = 1'b0;
  endtask

  initial begin
    logic seen_done;
    logic seen_busy;
    bus.start   = 1'b0;
    bus.pattern = 8'h00;
    model_q     = 1'b0;

    #6;
    chk("rst_jk",   32'({bus.j, bus.k}), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err",  32'(bus.err_cnt), 32'd0);
    chk("rst_idx",  32'(bus.cur_idx), 32'd0);
    #6 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("hold_idle", 32'({bus.j, bus.k, bus.busy, bus.done, bus.err_cnt}), 32'd0);
    end

    run(8'b1100_1010, 1'b0, 1'b0);
    chk("golden_ffq", 32'(ff_q), 32'd1);

    run(8'h5C, 1'b1, 1'b0);
    run(8'hA3, 1'b0, 1'b0);
    run(8'h3E, 1'b0, 1'b1);
    for (int n = 0; n < 6; n++) begin
      run(8'($urandom), 1'b0, 1'($urandom_range(1, 0)));
    end

    mode = 1;
    run(8'hFF, 1'b0, 1'b0);
    run(8'($urandom), 1'b0, 1'b0);
    mode = 2;
    run(8'h00, 1'b0, 1'b0);
    run(8'($urandom), 1'b0, 1'b1);
    mode = 0;
    pulse_reset();

    bus.pattern = 8'b1100_1010;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_pre_j", 32'({bus.j, bus.k}), 32'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_jk",   32'({bus.j, bus.k}), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_err",  32'(bus.err_cnt), 32'd0);
    chk("abort_idx",  32'(bus.cur_idx), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    model_q = 1'b0;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen_done = seen_done | bus.done;
      seen_busy = seen_busy | bus.busy;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    chk("abort_no_busy", 32'(seen_busy), 32'd0);
    run(8'b1100_1010, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jk_excite_driver.md
JK_EXCITE_DRIVER -- requirements
Module: jk_excite_driver

Interface
REQ-001 Parameter LEN, default 8, SHALL set the pattern length in bits; legal range is 1..16.
REQ-002 Parameter DC_VAL, default 1'b0, SHALL be the value driven on j or k wherever the JK excitation table entry is "don't care".
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request a run; it is sampled only in IDLE.
REQ-006 pattern  input  LEN  SHALL give the target Q sequence; pattern[0] is applied first.
REQ-007 q_fb  input  1  SHALL carry the Q output of the external JK flip-flop being driven.
REQ-008 j  output  1  SHALL be the J drive to the external flip-flop.
REQ-009 k  output  1  SHALL be the K drive to the external flip-flop.
REQ-010 busy  output  1  SHALL be high while a run is in progress (DRIVE, CHECK, FINISH).
REQ-011 done  output  1  SHALL pulse high for exactly one cycle at the end of each run.
REQ-012 err_cnt  output  $clog2(LEN+1)  SHALL report the number of mismatched bits in the last run.
REQ-013 cur_idx  output  $clog2(LEN) (minimum 1)  SHALL report the index of the bit currently being applied or checked.

Function
REQ-014 The FSM SHALL have four states: IDLE, DRIVE, CHECK and FINISH.
REQ-015 IDLE: j = k = 0 (hold), busy = 0 and done = 0.
  - start = 1 SHALL capture pattern into an internal register, clear cur_idx and err_cnt, and transition to DRIVE.
REQ-016 DRIVE SHALL last exactly one cycle, with j/k decoded combinationally from q_fb and target bit t = pattern_reg[cur_idx]:
  - q_fb=0, t=0 -> j=0, k=DC_VAL
  - q_fb=0, t=1 -> j=1, k=DC_VAL
  - q_fb=1, t=0 -> j=DC_VAL, k=1
  - q_fb=1, t=1 -> j=DC_VAL, k=0
  - Next state is CHECK.
REQ-017 CHECK SHALL last exactly one cycle, with j = k = 0.
  - If q_fb != pattern_reg[cur_idx], err_cnt SHALL increment, saturating at LEN.
  - If cur_idx == LEN-1, next state is FINISH; otherwise cur_idx increments and next state is DRIVE.
REQ-018 FINISH SHALL last exactly one cycle, with done = 1, busy = 1 and j = k = 0; next state is IDLE.
REQ-019 Latency: with start sampled at edge 0, DRIVE for bit i SHALL occupy cycle 2i+1, CHECK for bit i cycle 2i+2, and FINISH cycle 2*LEN+1.
REQ-020 start outside IDLE, including during FINISH, SHALL be ignored and SHALL NOT corrupt the run.
REQ-021 Changes on pattern after capture SHALL NOT affect the current run.
REQ-022 err_cnt and cur_idx SHALL hold their final values in IDLE until the next accepted start.
REQ-023 A start asserted in the first IDLE cycle after FINISH SHALL be accepted normally, giving back-to-back runs.
REQ-024 j and k SHALL never both be 1 unless DC_VAL = 1 and the decode requires it.
REQ-025 Only LEN = 1 wrap-around is special: cur_idx stays 0 and CHECK goes directly to FINISH.

Reset
REQ-026 rst_n = 0 SHALL immediately force the following, without waiting for a clock edge:
  - state = IDLE
  - j = 0, k = 0, busy = 0, done = 0
  - err_cnt = 0, cur_idx = 0
  - pattern_reg = 0
REQ-027 Reset asserted mid-run SHALL abort the run with no done pulse; after release the block waits in IDLE for start.
REQ-028 Deassertion of rst_n SHALL take effect at the next rising clk edge; no state change occurs in the cycle of release unless start is sampled.

Verification (LEN = 8, DC_VAL = 0, ideal JK FF model on q_fb, initial Q = 0 unless stated)
REQ-029 Idle reset: rst_n low for 12 ns, released, start = 0 -> j = k = busy = done = 0, err_cnt = 0, held indefinitely.
REQ-030 Golden run: pattern = 8'b1100_1010, start pulse -> done at cycle 17, err_cnt = 0, FF Q follows 0,1,0,1,0,0,1,1.
  - j/k in DRIVE for bits 0..3: (0,0), (1,0), (0,1), (1,0).
REQ-031 Stuck-at-0 FF: q_fb = 0, pattern = 8'hFF -> j = 1, k = 0 in every DRIVE; err_cnt = 8 at done.
REQ-032 Stuck-at-1 FF: q_fb = 1, pattern = 8'h00 -> j = 0, k = 1 in every DRIVE; err_cnt = 8 at done.
REQ-033 Abort and restart:
  - rst_n pulsed low in cycle 7 of a run -> outputs cleared asynchronously, no done pulse.
  - Fresh start then completes normally with done at cycle 17.
REQ-034 Start rules:
  - start held high through a run -> exactly one run, then a second run starts in the IDLE cycle after FINISH.
  - pattern changed mid-run -> no effect on j/k or err_cnt.
